// File: rtl/rb_approx_sub_pipe_pkg.sv
// Shared definitions for the approximate arithmetic blocks: the cell-kind enum,
// default sizing, and the one-bit full-subtractor equation used by every cell.
package approx_arith_pkg;

  typedef enum logic {
    CELL_EXACT  = 1'b0,
    CELL_APPROX = 1'b1
  } cell_kind_e;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_APPROX_BITS = 2;
  localparam int DEF_SPLIT       = 8;

  // Returns {bout, d}. The approximate cell drops the borrow-in term entirely,
  // so a borrow generated below it never reaches the bits above.
  function automatic logic [1:0] fs_cell(input logic a, input logic b,
                                         input logic bin, input cell_kind_e kind);
    logic d;
    logic bout;
    if (kind == CELL_APPROX) begin
      d    = a ^ b;
      bout = ~a & b;
    end else begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
    end
    return {bout, d};
  endfunction

endpackage

// File: rtl/rb_approx_sub_pipe_fs_cell.sv
// One-bit full subtractor; APPROX picks the approximate (borrow-in ignored) cell.
module approx_fs_cell
  import approx_arith_pkg::*;
#(
  parameter bit APPROX = 1'b0
) (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  localparam cell_kind_e KIND = APPROX ? CELL_APPROX : CELL_EXACT;

  assign {bout, d} = fs_cell(a, b, bin, KIND);

endmodule

// File: rtl/rb_approx_sub_pipe.sv
// Two-stage pipelined approximate ripple-borrow subtractor with valid/ready
// on both sides. Stage 1 ripples bits [SPLIT-1:0] straight off the inputs,
// stage 2 finishes [WIDTH-1:SPLIT] from the registered operands and borrow.
// Optional macro SUB_ERR_MON_EN adds an exact reference datapath and the
// err_clr/err_cnt/err_max error statistics ports.
module rb_approx_sub_pipe
  import approx_arith_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS,
  parameter int SPLIT       = DEF_SPLIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_diff
`ifdef SUB_ERR_MON_EN
  ,
  input  logic             err_clr,
  output logic [31:0]      err_cnt,
  output logic [WIDTH:0]   err_max
`endif
);

  localparam int STAGES = 2;

  logic [STAGES:1]      vld_pipe;
  logic                 s1_load, s2_load, s1_take, s2_take;

  logic [WIDTH-1:SPLIT] s1_a_hi, s1_b_hi;
  logic [SPLIT-1:0]     s1_dlo;
  logic                 s1_bor;

  logic [WIDTH-1:0]     op_a, op_b, bin_w, d;
  logic [WIDTH:0]       bc;

  // s2 frees up when empty or draining; s1 when empty or moving into s2.
  assign s2_load   = ~vld_pipe[2] | out_ready;
  assign s1_load   = ~vld_pipe[1] | s2_load;
  assign in_ready  = s1_load;
  assign s1_take   = in_valid & s1_load;
  assign s2_take   = vld_pipe[1] & s2_load;
  assign out_valid = vld_pipe[2];

  // One cell row: low bits fed from the ports, high bits from the s1 bank.
  assign op_a  = {s1_a_hi, in_a[SPLIT-1:0]};
  assign op_b  = {s1_b_hi, in_b[SPLIT-1:0]};
  assign bc[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      if (i == SPLIT) begin : g_brk
        assign bin_w[i] = s1_bor;
      end else begin : g_chain
        assign bin_w[i] = bc[i];
      end
      approx_fs_cell #(.APPROX(i < APPROX_BITS)) u_cell (
        .a    (op_a[i]),
        .b    (op_b[i]),
        .bin  (bin_w[i]),
        .d    (d[i]),
        .bout (bc[i+1])
      );
    end
  endgenerate

  // Valid bits: each stage takes the upstream valid whenever it may load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      if (s1_load) vld_pipe[1] <= in_valid;
      if (s2_load) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // Stage 1 bank: high operand bits, low difference, borrow at the split.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a_hi <= '0;
      s1_b_hi <= '0;
      s1_dlo  <= '0;
      s1_bor  <= 1'b0;
    end else if (s1_take) begin
      s1_a_hi <= in_a[WIDTH-1:SPLIT];
      s1_b_hi <= in_b[WIDTH-1:SPLIT];
      s1_dlo  <= d[SPLIT-1:0];
      s1_bor  <= bc[SPLIT];
    end
  end

  // Stage 2 bank: completed result; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_diff <= '0;
    end else if (s2_take) begin
      out_diff <= {bc[WIDTH], d[WIDTH-1:SPLIT], s1_dlo};
    end
  end

`ifdef SUB_ERR_MON_EN
  logic [SPLIT-1:0] s1_a_lo, s1_b_lo;
  logic [WIDTH:0]   s2_exact, abs_err;
  logic             xfer;

  assign xfer    = vld_pipe[2] & out_ready;
  assign abs_err = (out_diff > s2_exact) ? (out_diff - s2_exact) : (s2_exact - out_diff);

  // Low operand bits kept alongside stage 1 so stage 2 can form the exact result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a_lo <= '0;
      s1_b_lo <= '0;
    end else if (s1_take) begin
      s1_a_lo <= in_a[SPLIT-1:0];
      s1_b_lo <= in_b[SPLIT-1:0];
    end
  end

  // Exact reference {A<B, A-B}, advancing in lockstep with out_diff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_exact <= '0;
    end else if (s2_take) begin
      s2_exact <= {1'b0, s1_a_hi, s1_a_lo} - {1'b0, s1_b_hi, s1_b_lo};
    end
  end

  // Error statistics on delivered results; clear beats a same-cycle transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (xfer && (out_diff != s2_exact)) begin
      if (err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
      if (abs_err > err_max)        err_max <= abs_err;
    end
  end
`endif

endmodule

// File: tb/tb_rb_approx_sub_pipe.sv
// Directed bench for rb_approx_sub_pipe: a default-config instance
// (APPROX_BITS=2) and a fully exact one (APPROX_BITS=0) share all inputs.
module tb_rb_approx_sub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [15:0] in_a, in_b;
  logic        in_ready, in_ready_x, out_valid, out_valid_x;
  logic [16:0] out_diff, out_diff_x;
`ifdef SUB_ERR_MON_EN
  logic        err_clr;
  logic [31:0] err_cnt, err_cnt_x;
  logic [16:0] err_max, err_max_x;
`endif

  always #5 clk = ~clk;

  rb_approx_sub_pipe #(.WIDTH(16), .APPROX_BITS(2), .SPLIT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff)
`ifdef SUB_ERR_MON_EN
    , .err_clr(err_clr), .err_cnt(err_cnt), .err_max(err_max)
`endif
  );

  rb_approx_sub_pipe #(.WIDTH(16), .APPROX_BITS(0), .SPLIT(8)) dut_x (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_x),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_x), .out_ready(out_ready),
    .out_diff(out_diff_x)
`ifdef SUB_ERR_MON_EN
    , .err_clr(err_clr), .err_cnt(err_cnt_x), .err_max(err_max_x)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] ap;  // APPROX_BITS=2 result
    logic [16:0] ex;  // exact {A<B, A-B}
  } vec_t;

  vec_t tv[12];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Streams tv[0..n-1]; out_ready is low during stream cycles lo..hi.
  // Called at posedge+1.
  task automatic run_stream(input int n, input int lo, input int hi, input string tag);
    int          rx;
    bit          saw_low;
    bit          hold;
    logic [16:0] held;
    rx = 0; saw_low = 0; hold = 0; held = '0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          bit ok;
          in_valid = 1'b1; in_a = tv[i].a; in_b = tv[i].b;
          ok = 1'b0;
          for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            if (!in_ready) saw_low = 1'b1;
            @(posedge clk); #1;
          end
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 200 && rx < n; c++) begin
          out_ready = !(c >= lo && c <= hi);
          @(negedge clk);
          if (hold) begin
            chk({tag, "_stall_vld"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_stall_data"}, {15'd0, out_diff}, {15'd0, held});
          end
          hold = 1'b0;
          if (out_valid) begin
            if (out_ready) begin
              chk($sformatf("%s_ap[%0d]", tag, rx), {15'd0, out_diff}, {15'd0, tv[rx].ap});
              chk($sformatf("%s_ex[%0d]", tag, rx), {15'd0, out_diff_x}, {15'd0, tv[rx].ex});
              rx++;
            end else begin
              held = out_diff;
              hold = 1'b1;
            end
          end
          @(posedge clk); #1;
        end
        chk({tag, "_count"}, rx, n);
        out_ready = 1'b1;
      end
    join
    if (lo <= hi) chk({tag, "_in_ready_low"}, {31'd0, saw_low}, 32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
`ifdef SUB_ERR_MON_EN
    err_clr = 1'b0;
`endif
    tv[0]  = '{16'h0005, 16'h0003, 17'h00002, 17'h00002};
    tv[1]  = '{16'h0004, 16'h0001, 17'h00005, 17'h00003};
    tv[2]  = '{16'h0000, 16'h0001, 17'h00001, 17'h1FFFF};
    tv[3]  = '{16'hFFFF, 16'h0000, 17'h0FFFF, 17'h0FFFF};
    tv[4]  = '{16'h0000, 16'hFFFF, 17'h10003, 17'h10001};
    tv[5]  = '{16'h1234, 16'h0234, 17'h01000, 17'h01000};
    tv[6]  = '{16'h8000, 16'h8001, 17'h00001, 17'h1FFFF};
    tv[7]  = '{16'h00FF, 16'h0100, 17'h1FFFF, 17'h1FFFF};
    tv[8]  = '{16'h0100, 16'h0001, 17'h00101, 17'h000FF};
    tv[9]  = '{16'hABCD, 16'h1234, 17'h09999, 17'h09999};
    tv[10] = '{16'h7FFE, 16'h7FFF, 17'h00001, 17'h1FFFF};
    tv[11] = '{16'hFFFF, 16'hFFFF, 17'h00000, 17'h00000};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_diff", {15'd0, out_diff}, 32'd0);
`ifdef SUB_ERR_MON_EN
    chk("rst_err_cnt", err_cnt, 32'd0);
    chk("rst_err_max", {15'd0, err_max}, 32'd0);
`endif

    // Single pair: result two cycles after it is presented, held under stall.
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 16'h0005; in_b = 16'h0003; out_ready = 1'b0;
    @(negedge clk);
    chk("lat_c0_vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1_vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_c2_vld", {31'd0, out_valid}, 32'd1);
    chk("lat_c2_data", {15'd0, out_diff}, 32'h00002);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_hold_vld", {31'd0, out_valid}, 32'd1);
    chk("lat_hold_data", {15'd0, out_diff}, 32'h00002);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_drained", {31'd0, out_valid}, 32'd0);

    // Full table at one pair per cycle, no stall.
    @(posedge clk); #1;
    run_stream(12, -1, -2, "tab");
`ifdef SUB_ERR_MON_EN
    @(posedge clk); #1;
    chk("tab_err_cnt", err_cnt, 32'd6);
    chk("tab_err_max", {15'd0, err_max}, 32'h1FFFE);
    chk("tab_err_cnt_exact", err_cnt_x, 32'd0);
    chk("tab_err_max_exact", {15'd0, err_max_x}, 32'd0);

    // Clear coincides with a mismatching transfer: the transfer is not counted.
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 16'h0004; in_b = 16'h0001; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    chk("clr_vld", {31'd0, out_valid}, 32'd1);
    chk("clr_data", {15'd0, out_diff}, 32'h00005);
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("clr_err_cnt", err_cnt, 32'd0);
    chk("clr_err_max", {15'd0, err_max}, 32'd0);
`endif

    // Back-to-back 8 pairs with the consumer stalled for cycles 3-6.
    @(posedge clk); #1;
    run_stream(8, 3, 6, "stall");

    // Reset with two pairs in flight.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h0004; in_b = 16'h0001;
    @(posedge clk); #1 in_a = 16'h0000; in_b = 16'h0001;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("mid_pre_vld", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", {15'd0, out_diff}, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_no_stale", {31'd0, seen}, 32'd0);
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef SUB_ERR_MON_EN
    chk("mid_err_cnt", err_cnt, 32'd0);
    chk("mid_err_max", {15'd0, err_max}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
